// File: rtl/xdecdr_pend.sv
// Index-to-vector pending register: decodes posted event indices into a sticky
// one-hot pending vector, with per-index retire, bulk clear, masking and error flags.
module xdecdr_pend #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_vld,
  input  logic [IDX_W-1:0] set_idx,
  output logic             set_rdy,
  input  logic             clr_vld,
  input  logic [IDX_W-1:0] clr_idx,
  output logic             clr_rdy,
  input  logic             clr_all,
  input  logic [WIDTH-1:0] mask,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pend,
  output logic [WIDTH-1:0] pend_msk,
  output logic             any_pend,
  output logic [5:0]       pend_cnt,
  output logic [WIDTH-1:0] set_oh,
  output logic             set_oh_vld,
  output logic             ovf,
  output logic             bad_idx
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_n;
  logic   rdy;

  // Out-of-range indices decode to all-zero so they never touch pend.
  function automatic logic [WIDTH-1:0] decode(input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] oh;
    for (int k = 0; k < WIDTH; k++) oh[k] = (32'(idx) == 32'(k));
    return oh;
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(WIDTH);
  endfunction

  function automatic logic [5:0] popcnt(input logic [WIDTH-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int k = 0; k < WIDTH; k++) cnt = cnt + 6'(v[k]);
    return cnt;
  endfunction

  logic             set_acc, clr_acc, set_inr, clr_inr;
  logic [WIDTH-1:0] set_oh_acc, clr_oh, pend_n;
  logic             ovf_ev, bad_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      INIT: state_n = RUN;
      RUN:  state_n = RUN;
    endcase
  end

  always_comb begin
    set_acc    = set_vld & rdy;
    clr_acc    = clr_vld & rdy;
    set_inr    = in_range(set_idx);
    clr_inr    = in_range(clr_idx);
    set_oh_acc = set_acc ? decode(set_idx) : '0;
    clr_oh     = clr_acc ? decode(clr_idx) : '0;
    // Clear is applied before set, so a same-cycle set always survives.
    pend_n     = clr_all ? set_oh_acc : ((pend & ~clr_oh) | set_oh_acc);
    ovf_ev     = (|(set_oh_acc & pend & ~clr_oh)) & ~clr_all;
    bad_ev     = (set_acc & ~set_inr) | (clr_acc & ~clr_inr);
  end

  // Stage boundary: every output registered from pend_n / mask in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy        <= 1'b0;
      pend       <= '0;
      pend_msk   <= '0;
      any_pend   <= 1'b0;
      pend_cnt   <= '0;
      set_oh     <= '0;
      set_oh_vld <= 1'b0;
      ovf        <= 1'b0;
      bad_idx    <= 1'b0;
    end else begin
      rdy        <= (state_n == RUN);
      pend       <= pend_n;
      pend_msk   <= pend_n & mask;
      any_pend   <= |(pend_n & mask);
      pend_cnt   <= popcnt(pend_n);
      set_oh_vld <= set_acc & set_inr;
      if (set_acc && set_inr) set_oh <= set_oh_acc;
      ovf        <= ovf_ev | (ovf & ~err_clr);
      bad_idx    <= bad_ev | (bad_idx & ~err_clr);
    end
  end

  assign set_rdy = rdy;
  assign clr_rdy = rdy;

endmodule

// File: tb/tb_xdecdr_pend.sv
// Scoreboard bench for xdecdr_pend: a 32-bit instance checked against a bit-level
// model, plus a 20-bit instance for out-of-range index handling.
module tb_xdecdr_pend;

  logic        clk, rst_n;
  logic        set_vld, clr_vld, clr_all, err_clr;
  logic [4:0]  set_idx, clr_idx;
  logic [31:0] mask;
  logic        set_rdy, clr_rdy, any_pend, set_oh_vld, ovf, bad_idx;
  logic [31:0] pend, pend_msk, set_oh;
  logic [5:0]  pend_cnt;

  logic        b_set_vld, b_clr_vld, b_clr_all, b_err_clr;
  logic [4:0]  b_set_idx, b_clr_idx;
  logic [19:0] b_mask;
  logic        b_set_rdy, b_clr_rdy, b_any_pend, b_set_oh_vld, b_ovf, b_bad_idx;
  logic [19:0] b_pend, b_pend_msk, b_set_oh;
  logic [5:0]  b_pend_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pend, msk, soh;
    logic [5:0]  cnt;
    logic        any, sohv, ovf, bad, rdy;
  } exp_t;
  exp_t q[$];

  logic [31:0] m_pend, m_soh;
  logic        m_ovf, m_sohv, m_rdy;

  xdecdr_pend #(.WIDTH(32), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .set_vld(set_vld), .set_idx(set_idx), .set_rdy(set_rdy),
    .clr_vld(clr_vld), .clr_idx(clr_idx), .clr_rdy(clr_rdy),
    .clr_all(clr_all), .mask(mask), .err_clr(err_clr),
    .pend(pend), .pend_msk(pend_msk), .any_pend(any_pend), .pend_cnt(pend_cnt),
    .set_oh(set_oh), .set_oh_vld(set_oh_vld), .ovf(ovf), .bad_idx(bad_idx)
  );

  xdecdr_pend #(.WIDTH(20), .IDX_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .set_vld(b_set_vld), .set_idx(b_set_idx), .set_rdy(b_set_rdy),
    .clr_vld(b_clr_vld), .clr_idx(b_clr_idx), .clr_rdy(b_clr_rdy),
    .clr_all(b_clr_all), .mask(b_mask), .err_clr(b_err_clr),
    .pend(b_pend), .pend_msk(b_pend_msk), .any_pend(b_any_pend), .pend_cnt(b_pend_cnt),
    .set_oh(b_set_oh), .set_oh_vld(b_set_oh_vld), .ovf(b_ovf), .bad_idx(b_bad_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_soh = '0; m_ovf = 1'b0; m_sohv = 1'b0; m_rdy = 1'b0;
    q.delete();
  endtask

  task automatic idle();
    set_vld = 1'b0; clr_vld = 1'b0; clr_all = 1'b0; err_clr = 1'b0;
  endtask

  // Predict the next state from the currently driven inputs, then compare after the edge.
  task automatic step();
    exp_t        e;
    logic [31:0] np;
    logic        sa, ca, clrb, ovf_ev;
    sa = set_vld && m_rdy;
    ca = clr_vld && m_rdy;
    for (int b = 0; b < 32; b++) begin
      clrb  = clr_all || (ca && (clr_idx == 5'(b)));
      np[b] = (sa && (set_idx == 5'(b))) || (m_pend[b] && !clrb);
    end
    ovf_ev = sa && m_pend[set_idx] && !(clr_all || (ca && clr_idx == set_idx));
    m_ovf  = ovf_ev || (m_ovf && !err_clr);
    if (sa) m_soh = 32'h1 << set_idx;
    m_sohv = sa;
    m_pend = np;
    m_rdy  = 1'b1;
    e.pend = np;
    e.msk  = np & mask;
    e.any  = (np & mask) != 0;
    e.cnt  = 6'($countones(np));
    e.soh  = m_soh;
    e.sohv = m_sohv;
    e.ovf  = m_ovf;
    e.bad  = 1'b0;
    e.rdy  = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("pend",       pend,              e.pend);
    chk("pend_msk",   pend_msk,          e.msk);
    chk("any_pend",   32'(any_pend),     32'(e.any));
    chk("pend_cnt",   32'(pend_cnt),     32'(e.cnt));
    chk("set_oh",     set_oh,            e.soh);
    chk("set_oh_vld", 32'(set_oh_vld),   32'(e.sohv));
    chk("ovf",        32'(ovf),          32'(e.ovf));
    chk("bad_idx",    32'(bad_idx),      32'(e.bad));
    chk("rdy",        32'({set_rdy, clr_rdy}), 32'({e.rdy, e.rdy}));
  endtask

  task automatic do_set(input int idx);
    idle(); set_vld = 1'b1; set_idx = 5'(idx); step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pend"}, pend, 32'h0);
    chk({tag, "_msk"},  pend_msk, 32'h0);
    chk({tag, "_soh"},  set_oh, 32'h0);
    chk({tag, "_misc"}, 32'({any_pend, pend_cnt, set_oh_vld, ovf, bad_idx, set_rdy, clr_rdy}), 32'h0);
  endtask

  task automatic bstep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(); set_idx = '0; clr_idx = '0; mask = '1;
    b_set_vld = 1'b0; b_clr_vld = 1'b0; b_clr_all = 1'b0; b_err_clr = 1'b0;
    b_set_idx = '0; b_clr_idx = '0; b_mask = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");

    // Request held across reset release; INIT must not consume it.
    set_vld = 1'b1; set_idx = 5'd3;
    rst_n = 1'b1;
    chk("init_rdy", 32'(set_rdy), 32'h0);
    step();
    chk("init_not_taken", pend, 32'h0);
    step();
    chk("first_set_pend", pend, 32'h8);
    chk("first_set_oh", 32'({set_oh_vld, pend_cnt}), 32'({1'b1, 6'd1}));
    idle(); step();
    chk("oh_vld_pulse", 32'(set_oh_vld), 32'h0);

    // Set/clear race on the same index.
    idle(); set_vld = 1'b1; set_idx = 5'd4; clr_vld = 1'b1; clr_idx = 5'd3; step();
    chk("race_pre", pend, 32'h10);
    idle(); set_vld = 1'b1; set_idx = 5'd4; clr_vld = 1'b1; clr_idx = 5'd4; step();
    chk("race_pend", pend, 32'h10);
    chk("race_ovf", 32'(ovf), 32'h0);
    do_set(4);
    chk("ovf_set", 32'(ovf), 32'h1);
    idle(); err_clr = 1'b1; step();
    chk("ovf_clr", 32'(ovf), 32'h0);
    idle(); err_clr = 1'b1; set_vld = 1'b1; set_idx = 5'd4; step();
    chk("ovf_wins", 32'(ovf), 32'h1);
    idle(); err_clr = 1'b1; clr_vld = 1'b1; clr_idx = 5'd20; step();

    // Fill, then clr_all with a simultaneous set.
    for (int i = 0; i < 32; i++) do_set(i);
    chk("fill_pend", pend, 32'hFFFF_FFFF);
    chk("fill_cnt", 32'(pend_cnt), 32'd32);
    idle(); clr_all = 1'b1; set_vld = 1'b1; set_idx = 5'd7; step();
    chk("clr_all_pend", pend, 32'h80);
    chk("clr_all_cnt", 32'(pend_cnt), 32'd1);

    // Mask changes with no traffic.
    idle(); clr_all = 1'b1; set_vld = 1'b1; set_idx = 5'd8; step();
    do_set(9); do_set(10); do_set(11);
    idle(); mask = 32'h0000_0300; step();
    chk("mask_msk", pend_msk, 32'h300);
    chk("mask_any", 32'(any_pend), 32'h1);
    mask = 32'h0; step();
    chk("mask0_any", 32'(any_pend), 32'h0);
    chk("mask0_pend", pend, 32'hF00);
    mask = '1;

    // Randomised traffic against the model.
    for (int i = 0; i < 60; i++) begin
      set_vld = 1'($urandom_range(0, 1));
      set_idx = 5'($urandom_range(0, 31));
      clr_vld = 1'($urandom_range(0, 1));
      clr_idx = ($urandom_range(0, 2) == 0) ? set_idx : 5'($urandom_range(0, 31));
      clr_all = ($urandom_range(0, 9) == 0);
      err_clr = ($urandom_range(0, 7) == 0);
      mask    = $urandom;
      step();
    end
    mask = '1;

    // Asynchronous reset between edges.
    idle(); clr_all = 1'b1; set_vld = 1'b1; set_idx = 5'd0; step();
    do_set(2); do_set(5); do_set(7);
    chk("pre_rst_pend", pend, 32'hA5);
    idle();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    #2 rst_n = 1'b1;
    chk("post_rst_rdy", 32'(set_rdy), 32'h0);
    step();
    chk("rdy_back", 32'(set_rdy), 32'h1);
    do_set(1);
    chk("post_rst_set", pend, 32'h2);

    // Out-of-range indices on the 20-bit instance.
    b_set_vld = 1'b1; b_set_idx = 5'd2; bstep();
    chk("b_set2", 32'(b_pend), 32'h4);
    b_set_idx = 5'd25; bstep();
    chk("b_bad_pend", 32'(b_pend), 32'h4);
    chk("b_bad_flag", 32'(b_bad_idx), 32'h1);
    chk("b_bad_ohv", 32'(b_set_oh_vld), 32'h0);
    chk("b_bad_oh", 32'(b_set_oh), 32'h4);
    b_set_vld = 1'b0; b_clr_vld = 1'b1; b_clr_idx = 5'd31; bstep();
    chk("b_clr31_flag", 32'(b_bad_idx), 32'h1);
    chk("b_clr31_pend", 32'(b_pend), 32'h4);
    b_clr_vld = 1'b0; b_err_clr = 1'b1; bstep();
    chk("b_err_clr", 32'(b_bad_idx), 32'h0);
    b_clr_vld = 1'b1; b_clr_idx = 5'd20; bstep();
    chk("b_bad_wins", 32'(b_bad_idx), 32'h1);
    b_clr_vld = 1'b1; b_clr_idx = 5'd19; b_err_clr = 1'b0; bstep();
    chk("b_clr_unset", 32'(b_pend), 32'h4);
    chk("b_ovf", 32'(b_ovf), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
